viterbi_acs_stage: RTL and testbench
====================================

Name: viterbi_acs_stage

Overview:
Add-compare-select block for a 4-state (K=3, rate-1/2) register-exchange Viterbi decoder. It has two independent datapaths that share clock and reset.
- First datapath (f_*): handles the first trellis step. It produces a 3-bit survivor label per state.
- Second datapath (s_*): handles every later step. It extends 8-bit register-exchange survivor paths.

Each datapath compares two candidate metrics per state and keeps the smaller one. It sits between the branch-metric unit and the traceback/output stage.

Parameters:
MW, 4, metric width (unsigned)
PW, 8, survivor path width in the s_ datapath

Ports:
clk  input  1  clock, all logic on the rising edge
rst  input  1  reset
f_valid_in  input  1  f_ inputs valid this cycle
f_bm_SS_b (SS in 00,01,10,11; b in 0,1)  input  MW each  candidate metric for state SS via input-branch b (8 ports)
f_new_bm_SS  output  MW each  selected metric for state SS (4 ports)
f_sel_SS  output  3 each  survivor label {SS, chosen b} (4 ports)
f_valid_out  output  1  f_ outputs updated
s_valid_in  input  1  s_ inputs valid
s_bm_SS_b  input  MW each  candidate metric for state SS from predecessor b (8 ports)
s_path_SS  input  PW each  current survivor path of state SS (4 ports)
s_new_bm_SS  output  MW each  selected metric (4 ports)
s_new_path_SS  output  PW each  updated survivor path (4 ports)
s_valid_out  output  1  s_ outputs updated

Interface rule (already decided): one clock; reset is synchronous and active-high. The clock port is named clk and the reset port is named rst.

Behaviour:
- Reset: when rst=1 at a clock edge, every output register is cleared to 0. This covers all metrics, f_sel, s_new_path and both valid_out bits. rst takes priority over valid_in.
- Latency: 1 cycle. Inputs sampled at edge N with valid_in=1 appear at the outputs after edge N. valid_out goes to 1 in that same cycle.
- valid_in=0 at an edge: valid_out goes to 0 and all data outputs hold their previous values.
- The two datapaths are fully independent. Each valid pair affects only its own outputs.
- Compare, per state SS: sel = (bm_SS_1 < bm_SS_0), an unsigned compare. A tie selects branch 0. new_bm_SS = the selected candidate, passed through unchanged with no add and no normalisation.
- First datapath: f_sel_SS = {SS[1:0], sel}.
- Second datapath trellis: state {a,c}, where c is the newest decoded bit.
  - Predecessor for sel=0 is state {0,a}; for sel=1 it is state {1,a}.
  - This gives: state 00 from 00/10, state 01 from 00/10, state 10 from 01/11, state 11 from 01/11.
- s_new_path_SS = {pred_path[PW-2:0], c}. The chosen predecessor's path is shifted left by one, its MSB is dropped, and the state's own LSB (c) is appended.
- Every output is registered. No combinational path runs from input to output.
- Reset asserted mid-stream: outputs are 0 on the next edge and valid_out is 0. After rst deasserts, operation resumes normally on the next valid input.

Test Plan:
- f_ basic: bm 00:1/3, 01:2/4, 10:2/1, 11:2/3 -> next cycle new_bm 1,2,1,2; sel 000,010,101,110; f_valid_out=1.
- f_ ties and extremes: all candidates=2 -> metrics 2,2,2,2, sel 000,010,100,110. Then 00:0/15, 01:15/0, 10:0/15, 11:15/0 -> metrics all 0, sel 000,011,100,111.
- s_ basic: bm 00:1/2, 01:3/4, 10:2/1, 11:4/3; paths AA,CC,F0,0F -> new_bm 1,3,1,3; new_path 54,55,1E,1F.
- s_ all-ones paths: bm 00:1/4, 01:4/1, 10:2/3, 11:3/2; paths FF -> new_bm 1,1,2,2; new_path FE,FF,FE,FF.
- Valid hold: load any vector, then drop both valid_in for 2 cycles -> valid_out=0 and outputs unchanged. Raise valid_in again -> new results after 1 cycle.
- Reset mid-operation: assert rst for 1 edge while valid_in=1 -> all outputs and valid_out become 0. After release, the first valid vector produces correct results 1 cycle later.

Source files
------------

// File: rtl/viterbi_acs_stage_if.sv
// Bundle of the f_ (first trellis step) and s_ (later steps) datapath signals
// of the 4-state add-compare-select stage. Arrays are indexed by state {a,c}
// and, for candidate metrics, by input branch / predecessor select b.
interface viterbi_acs_stage_if #(
    parameter int MW = 4,
    parameter int PW = 8
);
    // first-step datapath
    logic          f_valid_i;
    logic [MW-1:0] f_bm_i     [4][2];
    logic [MW-1:0] f_new_bm_o [4];
    logic [2:0]    f_sel_o    [4];
    logic          f_valid_o;

    // later-step datapath
    logic          s_valid_i;
    logic [MW-1:0] s_bm_i       [4][2];
    logic [PW-1:0] s_path_i     [4];
    logic [MW-1:0] s_new_bm_o   [4];
    logic [PW-1:0] s_new_path_o [4];
    logic          s_valid_o;

    // producer side: branch-metric unit / testbench
    modport master (
        output f_valid_i, f_bm_i, s_valid_i, s_bm_i, s_path_i,
        input  f_new_bm_o, f_sel_o, f_valid_o, s_new_bm_o, s_new_path_o, s_valid_o
    );

    // consumer side: the ACS stage itself
    modport slave (
        input  f_valid_i, f_bm_i, s_valid_i, s_bm_i, s_path_i,
        output f_new_bm_o, f_sel_o, f_valid_o, s_new_bm_o, s_new_path_o, s_valid_o
    );
endinterface

// File: rtl/viterbi_acs_stage.sv
// Add-compare-select stage for a K=3 rate-1/2 register-exchange Viterbi
// decoder. Two independent datapaths share clk/rst:
//   f_ : first trellis step, emits a 3-bit survivor label {state, b}.
//   s_ : later steps, extends PW-bit register-exchange survivor paths.
// State encoding is {a,c} with c the newest decoded bit; the predecessor for
// select b is state {b,a}. All outputs are registered, latency one cycle.
module viterbi_acs_stage #(
    parameter int MW = 4,
    parameter int PW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    viterbi_acs_stage_if.slave   bus
);

    // Branch 1 wins only when strictly smaller, so ties resolve to branch 0.
    function automatic logic acs_pick(input logic [MW-1:0] bm0, input logic [MW-1:0] bm1);
        return (bm1 < bm0);
    endfunction

    // combinational candidates
    logic          f_pick_s [4];
    logic [MW-1:0] f_min_s  [4];
    logic [2:0]    f_lab_s  [4];
    logic          s_pick_s [4];
    logic [MW-1:0] s_min_s  [4];
    logic [1:0]    s_pred_s [4];
    logic [PW-1:0] s_path_s [4];

    // registered state and its next value
    logic          f_valid_q, f_valid_d;
    logic [MW-1:0] f_bm_q   [4];
    logic [MW-1:0] f_bm_d   [4];
    logic [2:0]    f_sel_q  [4];
    logic [2:0]    f_sel_d  [4];
    logic          s_valid_q, s_valid_d;
    logic [MW-1:0] s_bm_q   [4];
    logic [MW-1:0] s_bm_d   [4];
    logic [PW-1:0] s_path_q [4];
    logic [PW-1:0] s_path_d [4];

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_state
            localparam logic [1:0] SS = 2'(g);

            assign f_pick_s[g] = acs_pick(bus.f_bm_i[g][0], bus.f_bm_i[g][1]);
            assign f_min_s[g]  = f_pick_s[g] ? bus.f_bm_i[g][1] : bus.f_bm_i[g][0];
            assign f_lab_s[g]  = {SS, f_pick_s[g]};

            assign s_pick_s[g] = acs_pick(bus.s_bm_i[g][0], bus.s_bm_i[g][1]);
            assign s_min_s[g]  = s_pick_s[g] ? bus.s_bm_i[g][1] : bus.s_bm_i[g][0];
            // predecessor of {a,c} under select b is {b,a}
            assign s_pred_s[g] = {s_pick_s[g], SS[1]};
            // shift survivor left, drop its MSB, append this state's own bit c
            assign s_path_s[g] = {bus.s_path_i[s_pred_s[g]][PW-2:0], SS[0]};

            assign bus.f_new_bm_o[g]   = f_bm_q[g];
            assign bus.f_sel_o[g]      = f_sel_q[g];
            assign bus.s_new_bm_o[g]   = s_bm_q[g];
            assign bus.s_new_path_o[g] = s_path_q[g];
        end
    endgenerate

    assign bus.f_valid_o = f_valid_q;
    assign bus.s_valid_o = s_valid_q;

    // Next-state: each datapath loads fresh results on its own valid, else holds.
    always_comb begin
        f_valid_d = bus.f_valid_i;
        s_valid_d = bus.s_valid_i;
        f_bm_d    = f_bm_q;
        f_sel_d   = f_sel_q;
        s_bm_d    = s_bm_q;
        s_path_d  = s_path_q;
        if (bus.f_valid_i) begin
            f_bm_d  = f_min_s;
            f_sel_d = f_lab_s;
        end else begin
            f_bm_d  = f_bm_q;
            f_sel_d = f_sel_q;
        end
        if (bus.s_valid_i) begin
            s_bm_d   = s_min_s;
            s_path_d = s_path_s;
        end else begin
            s_bm_d   = s_bm_q;
            s_path_d = s_path_q;
        end
    end

    // Output registers with synchronous reset taking priority over valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            f_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                f_bm_q[i]   <= {MW{1'b0}};
                f_sel_q[i]  <= 3'b000;
                s_bm_q[i]   <= {MW{1'b0}};
                s_path_q[i] <= {PW{1'b0}};
            end
        end else begin
            f_valid_q <= f_valid_d;
            s_valid_q <= s_valid_d;
            for (int i = 0; i < 4; i++) begin
                f_bm_q[i]   <= f_bm_d[i];
                f_sel_q[i]  <= f_sel_d[i];
                s_bm_q[i]   <= s_bm_d[i];
                s_path_q[i] <= s_path_d[i];
            end
        end
    end

endmodule

// File: tb/tb_viterbi_acs_stage.sv
// Self-checking bench for viterbi_acs_stage: directed vectors with literal
// expectations, then randomized traffic against a behavioural trellis model.
module tb_viterbi_acs_stage;

    localparam int MW = 4;
    localparam int PW = 8;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    // reference model of what the outputs should show
    int m_f_bm   [4];
    int m_f_sel  [4];
    int m_f_v;
    int m_s_bm   [4];
    int m_s_path [4];
    int m_s_v;

    viterbi_acs_stage_if #(.MW(MW), .PW(PW)) bus ();

    viterbi_acs_stage #(.MW(MW), .PW(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: each state keeps the smaller candidate (tie -> branch 0). A
    // survivor into state s = 2a+c comes from state choice*2 + a; its path is
    // the predecessor path times two plus c, truncated to PW bits.
    task automatic model_edge();
        int b0, b1, ch, a, c;
        if (rst) begin
            m_f_v = 0; m_s_v = 0;
            for (int s = 0; s < 4; s++) begin
                m_f_bm[s] = 0; m_f_sel[s] = 0; m_s_bm[s] = 0; m_s_path[s] = 0;
            end
        end else begin
            m_f_v = int'(bus.f_valid_i);
            m_s_v = int'(bus.s_valid_i);
            if (bus.f_valid_i) begin
                for (int s = 0; s < 4; s++) begin
                    b0 = int'(bus.f_bm_i[s][0]);
                    b1 = int'(bus.f_bm_i[s][1]);
                    ch = (b1 < b0) ? 1 : 0;
                    m_f_bm[s]  = ch ? b1 : b0;
                    m_f_sel[s] = s * 2 + ch;
                end
            end
            if (bus.s_valid_i) begin
                for (int s = 0; s < 4; s++) begin
                    b0 = int'(bus.s_bm_i[s][0]);
                    b1 = int'(bus.s_bm_i[s][1]);
                    ch = (b1 < b0) ? 1 : 0;
                    a  = s / 2;
                    c  = s % 2;
                    m_s_bm[s]   = ch ? b1 : b0;
                    m_s_path[s] = (int'(bus.s_path_i[ch * 2 + a]) * 2 + c) % 256;
                end
            end
        end
    endtask

    // advance one clock, model the edge, then settle away from the edge
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, " f_valid"}, int'(bus.f_valid_o), m_f_v);
        chk({tag, " s_valid"}, int'(bus.s_valid_o), m_s_v);
        for (int s = 0; s < 4; s++) begin
            chk($sformatf("%s f_bm[%0d]", tag, s),   int'(bus.f_new_bm_o[s]),   m_f_bm[s]);
            chk($sformatf("%s f_sel[%0d]", tag, s),  int'(bus.f_sel_o[s]),      m_f_sel[s]);
            chk($sformatf("%s s_bm[%0d]", tag, s),   int'(bus.s_new_bm_o[s]),   m_s_bm[s]);
            chk($sformatf("%s s_path[%0d]", tag, s), int'(bus.s_new_path_o[s]), m_s_path[s]);
        end
    endtask

    task automatic lit_f(input string tag, input int m0, input int m1, input int m2, input int m3,
                         input int s0, input int s1, input int s2, input int s3);
        chk({tag, " f_bm0"}, int'(bus.f_new_bm_o[0]), m0);
        chk({tag, " f_bm1"}, int'(bus.f_new_bm_o[1]), m1);
        chk({tag, " f_bm2"}, int'(bus.f_new_bm_o[2]), m2);
        chk({tag, " f_bm3"}, int'(bus.f_new_bm_o[3]), m3);
        chk({tag, " f_sel0"}, int'(bus.f_sel_o[0]), s0);
        chk({tag, " f_sel1"}, int'(bus.f_sel_o[1]), s1);
        chk({tag, " f_sel2"}, int'(bus.f_sel_o[2]), s2);
        chk({tag, " f_sel3"}, int'(bus.f_sel_o[3]), s3);
    endtask

    task automatic lit_s(input string tag, input int m0, input int m1, input int m2, input int m3,
                         input int p0, input int p1, input int p2, input int p3);
        chk({tag, " s_bm0"}, int'(bus.s_new_bm_o[0]), m0);
        chk({tag, " s_bm1"}, int'(bus.s_new_bm_o[1]), m1);
        chk({tag, " s_bm2"}, int'(bus.s_new_bm_o[2]), m2);
        chk({tag, " s_bm3"}, int'(bus.s_new_bm_o[3]), m3);
        chk({tag, " s_path0"}, int'(bus.s_new_path_o[0]), p0);
        chk({tag, " s_path1"}, int'(bus.s_new_path_o[1]), p1);
        chk({tag, " s_path2"}, int'(bus.s_new_path_o[2]), p2);
        chk({tag, " s_path3"}, int'(bus.s_new_path_o[3]), p3);
    endtask

    task automatic set_f(input int a0, input int a1, input int b0, input int b1,
                         input int c0, input int c1, input int d0, input int d1);
        bus.f_bm_i[0][0] = MW'(a0); bus.f_bm_i[0][1] = MW'(a1);
        bus.f_bm_i[1][0] = MW'(b0); bus.f_bm_i[1][1] = MW'(b1);
        bus.f_bm_i[2][0] = MW'(c0); bus.f_bm_i[2][1] = MW'(c1);
        bus.f_bm_i[3][0] = MW'(d0); bus.f_bm_i[3][1] = MW'(d1);
    endtask

    task automatic set_s(input int a0, input int a1, input int b0, input int b1,
                         input int c0, input int c1, input int d0, input int d1,
                         input int p0, input int p1, input int p2, input int p3);
        bus.s_bm_i[0][0] = MW'(a0); bus.s_bm_i[0][1] = MW'(a1);
        bus.s_bm_i[1][0] = MW'(b0); bus.s_bm_i[1][1] = MW'(b1);
        bus.s_bm_i[2][0] = MW'(c0); bus.s_bm_i[2][1] = MW'(c1);
        bus.s_bm_i[3][0] = MW'(d0); bus.s_bm_i[3][1] = MW'(d1);
        bus.s_path_i[0] = PW'(p0); bus.s_path_i[1] = PW'(p1);
        bus.s_path_i[2] = PW'(p2); bus.s_path_i[3] = PW'(p3);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.f_valid_i = 1'b0;
        bus.s_valid_i = 1'b0;
        set_f(0, 0, 0, 0, 0, 0, 0, 0);
        set_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // reset state
        tick(); tick();
        chk("reset f_valid", int'(bus.f_valid_o), 0);
        chk("reset s_valid", int'(bus.s_valid_o), 0);
        lit_f("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        lit_s("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // f basic + s basic together
        bus.f_valid_i = 1'b1;
        bus.s_valid_i = 1'b1;
        set_f(1, 3, 2, 4, 2, 1, 2, 3);
        set_s(1, 2, 3, 4, 2, 1, 4, 3, 'hAA, 'hCC, 'hF0, 'h0F);
        tick();
        chk("basic f_valid", int'(bus.f_valid_o), 1);
        chk("basic s_valid", int'(bus.s_valid_o), 1);
        lit_f("f_basic", 1, 2, 1, 2, 3'b000, 3'b010, 3'b101, 3'b110);
        lit_s("s_basic", 1, 3, 1, 3, 'h54, 'h55, 'h1E, 'h1F);
        check_model("basic");

        // ties on f, all-ones paths on s
        set_f(2, 2, 2, 2, 2, 2, 2, 2);
        set_s(1, 4, 4, 1, 2, 3, 3, 2, 'hFF, 'hFF, 'hFF, 'hFF);
        tick();
        lit_f("f_ties", 2, 2, 2, 2, 3'b000, 3'b010, 3'b100, 3'b110);
        lit_s("s_ones", 1, 1, 2, 2, 'hFE, 'hFF, 'hFE, 'hFF);
        check_model("ties");

        // extremes on f only; s idle so it must hold
        bus.s_valid_i = 1'b0;
        set_f(0, 15, 15, 0, 0, 15, 15, 0);
        tick();
        lit_f("f_extreme", 0, 0, 0, 0, 3'b000, 3'b011, 3'b100, 3'b111);
        chk("indep s_valid", int'(bus.s_valid_o), 0);
        lit_s("indep s_hold", 1, 1, 2, 2, 'hFE, 'hFF, 'hFE, 'hFF);
        check_model("extreme");

        // valid hold: both valids low for two cycles, inputs scrambled
        bus.f_valid_i = 1'b0;
        set_f(9, 8, 7, 6, 5, 4, 3, 2);
        set_s(9, 8, 7, 6, 5, 4, 3, 2, 'h12, 'h34, 'h56, 'h78);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("hold f_valid", int'(bus.f_valid_o), 0);
            chk("hold s_valid", int'(bus.s_valid_o), 0);
            lit_f("hold", 0, 0, 0, 0, 3'b000, 3'b011, 3'b100, 3'b111);
            lit_s("hold", 1, 1, 2, 2, 'hFE, 'hFF, 'hFE, 'hFF);
        end
        bus.f_valid_i = 1'b1;
        bus.s_valid_i = 1'b1;
        tick();
        check_model("resume");

        // reset mid-operation with valid high
        rst = 1'b1;
        set_f(1, 3, 2, 4, 2, 1, 2, 3);
        tick();
        chk("midrst f_valid", int'(bus.f_valid_o), 0);
        chk("midrst s_valid", int'(bus.s_valid_o), 0);
        lit_f("midrst", 0, 0, 0, 0, 0, 0, 0, 0);
        lit_s("midrst", 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        set_s(1, 2, 3, 4, 2, 1, 4, 3, 'hAA, 'hCC, 'hF0, 'h0F);
        tick();
        lit_f("post_rst", 1, 2, 1, 2, 3'b000, 3'b010, 3'b101, 3'b110);
        lit_s("post_rst", 1, 3, 1, 3, 'h54, 'h55, 'h1E, 'h1F);
        check_model("post_rst");

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 39) == 0);
            bus.f_valid_i = ($urandom_range(0, 3) != 0);
            bus.s_valid_i = ($urandom_range(0, 3) != 0);
            for (int s = 0; s < 4; s++) begin
                for (int b = 0; b < 2; b++) begin
                    bus.f_bm_i[s][b] = MW'($urandom_range(0, 15));
                    bus.s_bm_i[s][b] = ($urandom_range(0, 4) == 0) ? bus.s_bm_i[s][0]
                                                                   : MW'($urandom_range(0, 15));
                end
                bus.s_path_i[s] = PW'($urandom_range(0, 255));
            end
            tick();
            check_model("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
